// File: rtl/global_defs_pkg.sv
// Shared types for the trace front end: parser opcodes, request record
// and the release FSM encoding used by trace_request_buffer.
package global_defs_pkg;

  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_TIME_WIDTH    = 64;
  localparam int DEF_CORE_WIDTH    = 4;

  // Opcodes produced by the trace parser.
  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2
  } parsed_op_t;

  // One parsed request at the default field widths. The buffer itself packs
  // the same fields in the same order (time, core, opcode, address) at its
  // parametrised widths.
  typedef struct packed {
    logic [DEF_TIME_WIDTH-1:0]    req_time;
    logic [DEF_CORE_WIDTH-1:0]    core;
    parsed_op_t                   opcode;
    logic [DEF_ADDRESS_WIDTH-1:0] address;
  } trace_req_t;

  // Release FSM: IDLE = empty, WAIT = head not yet due, ISSUE = out_valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } buffer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO storage with occupancy count. Besides the head entry it
// exposes the upper PEEK_WIDTH bits of the entry behind the head, so the
// owner can predict what the head will look like after a pop.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int PEEK_WIDTH = WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [PEEK_WIDTH-1:0]      rd_peek_next,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic             push_ok;
  logic             pop_ok;

  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign push_ok      = push && !full;
  assign pop_ok       = pop && !empty;
  assign rd_ptr_inc   = rd_ptr + AW'(1);
  assign rd_data      = mem[rd_ptr];
  assign rd_peek_next = mem[rd_ptr_inc][WIDTH-1 -: PEEK_WIDTH];

  // Pointers wrap modulo DEPTH; count tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr_inc;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/trace_request_buffer.sv
// Buffers parsed trace requests and releases each one to the memory
// controller once the simulated CPU clock reaches its arrival time.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid never depends on ready, and the payload is held stable while
// valid is high and ready is low.
module trace_request_buffer
  import global_defs_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIME_WIDTH    = 64,
  parameter int CORE_WIDTH    = 4,
  parameter int DEPTH         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TIME_WIDTH-1:0]      in_time,
  input  logic [CORE_WIDTH-1:0]      in_core,
  input  parsed_op_t                 in_opcode,
  input  logic [ADDRESS_WIDTH-1:0]   in_address,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TIME_WIDTH-1:0]      out_time,
  output logic [CORE_WIDTH-1:0]      out_core,
  output parsed_op_t                 out_opcode,
  output logic [ADDRESS_WIDTH-1:0]   out_address,
  output logic [TIME_WIDTH-1:0]      clock_count,
  input  logic                       skip_en,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       order_err,
  output buffer_state_t              state
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int OPW = $bits(parsed_op_t);
  localparam int EW  = TIME_WIDTH + CORE_WIDTH + OPW + ADDRESS_WIDTH;

  logic [EW-1:0]         wr_data;
  logic [EW-1:0]         head_data;
  logic [TIME_WIDTH-1:0] head_time;
  logic [TIME_WIDTH-1:0] second_time;
  logic [TIME_WIDTH-1:0] last_time;
  logic [TIME_WIDTH-1:0] store_time;
  logic [TIME_WIDTH-1:0] clock_next;
  logic [TIME_WIDTH-1:0] next_head_time;
  logic [TIME_WIDTH:0]   clock_plus_one;
  logic                  out_of_order;
  logic                  push;
  logic                  pop;
  logic                  skip;
  logic                  will_be_empty;
  buffer_state_t         state_next;

  assign in_ready     = !full;
  assign push         = in_valid && in_ready;
  assign out_of_order = (in_time < last_time);
  assign store_time   = out_of_order ? last_time : in_time;
  assign wr_data      = {store_time, in_core, in_opcode, in_address};

  sync_fifo #(
    .WIDTH      (EW),
    .DEPTH      (DEPTH),
    .PEEK_WIDTH (TIME_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .wr_data      (wr_data),
    .rd_data      (head_data),
    .rd_peek_next (second_time),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  assign head_time = head_data[EW-1 -: TIME_WIDTH];
  assign out_valid = !empty && (head_time <= clock_count);
  assign pop       = out_valid && out_ready;

  // Fields read as zero while empty so no stale entry leaks after reset.
  assign out_time    = empty ? '0 : head_time;
  assign out_core    = empty ? '0 : head_data[ADDRESS_WIDTH+OPW +: CORE_WIDTH];
  assign out_opcode  = empty ? OP_READ : parsed_op_t'(head_data[ADDRESS_WIDTH +: OPW]);
  assign out_address = empty ? '0 : head_data[ADDRESS_WIDTH-1:0];

  // Next clock count: jump straight to a far-off head time when skipping,
  // otherwise count up and stick at all-ones.
  always_comb begin
    clock_next     = clock_count;
    clock_plus_one = {1'b0, clock_count} + (TIME_WIDTH+1)'(1);
    skip           = skip_en && !empty && ({1'b0, head_time} > clock_plus_one);
    if (skip) begin
      clock_next = head_time;
    end else if (clock_count != '1) begin
      clock_next = clock_count + TIME_WIDTH'(1);
    end
  end

  // Predict the post-edge head and occupancy so the registered state
  // matches the FIFO contents and clock count right after each edge.
  always_comb begin
    next_head_time = head_time;
    will_be_empty  = (empty && !push) || ((count == CW'(1)) && pop && !push);
    if (empty || (pop && count == CW'(1))) begin
      next_head_time = store_time;
    end else if (pop) begin
      next_head_time = second_time;
    end
    state_next = IDLE;
    if (!will_be_empty) begin
      state_next = (next_head_time <= clock_next) ? ISSUE : WAIT;
    end
  end

  // Release FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Simulated CPU clock, last pushed time and sticky ordering flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clock_count <= '0;
      last_time   <= '0;
      order_err   <= 1'b0;
    end else begin
      clock_count <= clock_next;
      if (push) begin
        last_time <= store_time;
        if (out_of_order) order_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_request_buffer.sv
// Bench for trace_request_buffer: directed scenarios followed by random
// traffic, with every cycle compared against a queue-based reference.
module tb_trace_request_buffer;
  import global_defs_pkg::*;

  localparam int AW    = 32;
  localparam int TW    = 64;
  localparam int CRW   = 4;
  localparam int DEPTH = 16;
  localparam int NW    = $clog2(DEPTH+1);
  localparam int EW    = TW + CRW + 2 + AW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [TW-1:0]   in_time = '0;
  logic [CRW-1:0]  in_core = '0;
  parsed_op_t      in_opcode = OP_READ;
  logic [AW-1:0]   in_address = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [TW-1:0]   out_time;
  logic [CRW-1:0]  out_core;
  parsed_op_t      out_opcode;
  logic [AW-1:0]   out_address;
  logic [TW-1:0]   clock_count;
  logic            skip_en = 1'b0;
  logic [NW-1:0]   count;
  logic            full;
  logic            empty;
  logic            order_err;
  buffer_state_t   state;

  // Clock / reset block
  always #5 clk = ~clk;

  trace_request_buffer #(
    .ADDRESS_WIDTH (AW),
    .TIME_WIDTH    (TW),
    .CORE_WIDTH    (CRW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_time     (in_time),
    .in_core     (in_core),
    .in_opcode   (in_opcode),
    .in_address  (in_address),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_time    (out_time),
    .out_core    (out_core),
    .out_opcode  (out_opcode),
    .out_address (out_address),
    .clock_count (clock_count),
    .skip_en     (skip_en),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .order_err   (order_err),
    .state       (state)
  );

  // Scoreboard: reference queue of stored entries {time, core, op, addr}
  logic [EW-1:0] exp_q[$];
  logic [TW-1:0] m_cc;
  logic [TW-1:0] m_last;
  logic          m_oerr;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    m_cc   = '0;
    m_last = '0;
    m_oerr = 1'b0;
  endtask

  function automatic logic [TW-1:0] head_t();
    logic [EW-1:0] h;
    h = exp_q[0];
    return h[EW-1 -: TW];
  endfunction

  function automatic logic model_valid();
    return (exp_q.size() != 0) && (head_t() <= m_cc);
  endfunction

  task automatic check_reset_values();
    chk("rst_clock_count", clock_count, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_order_err", order_err, 0);
    chk("rst_state", state, IDLE);
    chk("rst_out_fields", {out_time, out_core, out_opcode, out_address}, 0);
  endtask

  task automatic check_model();
    logic [EW-1:0] h;
    buffer_state_t es;
    h  = (exp_q.size() != 0) ? exp_q[0] : '0;
    es = IDLE;
    if (exp_q.size() != 0) es = (head_t() <= m_cc) ? ISSUE : WAIT;
    chk("out_valid", out_valid, model_valid());
    chk("clock_count", clock_count, m_cc);
    chk("count", count, exp_q.size());
    chk("empty", empty, exp_q.size() == 0);
    chk("full", full, exp_q.size() == DEPTH);
    chk("in_ready", in_ready, exp_q.size() < DEPTH);
    chk("order_err", order_err, m_oerr);
    chk("state", state, es);
    chk("out_entry", {out_time, out_core, out_opcode, out_address}, h);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic          push_f;
    logic          pop_f;
    logic [TW-1:0] t;
    logic [TW-1:0] next_cc;
    @(negedge clk);
    check_model();
    push_f = in_valid && (exp_q.size() < DEPTH);
    pop_f  = model_valid() && out_ready;
    next_cc = (m_cc == '1) ? m_cc : m_cc + 1;
    if (skip_en && exp_q.size() != 0 && head_t() > m_cc + 1) next_cc = head_t();
    @(posedge clk);
    m_cc = next_cc;
    if (pop_f) void'(exp_q.pop_front());
    if (push_f) begin
      t = in_time;
      if (t < m_last) begin
        t = m_last;
        m_oerr = 1'b1;
      end
      m_last = t;
      exp_q.push_back({t, in_core, in_opcode, in_address});
    end
    #1;
  endtask

  // Driver tasks
  task automatic set_push(input logic v, input logic [TW-1:0] t);
    in_valid   = v;
    in_time    = t;
    in_core    = CRW'($urandom_range(0, 15));
    in_opcode  = parsed_op_t'($urandom_range(0, 2));
    in_address = $urandom;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    skip_en   = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;
    reset_model();
  endtask

  logic rose;

  initial begin
    reset_model();
    #1 check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (20) cycle();
    chk("idle_clock_count", clock_count, 20);
    chk("idle_empty", empty, 1);
    chk("idle_state", state, IDLE);
    chk("idle_out_valid", out_valid, 0);

    // Single request due at time 5, pushed at clock_count 2
    do_reset();
    repeat (2) cycle();
    out_ready = 1'b1;
    set_push(1'b1, 5);
    cycle();
    in_valid = 1'b0;
    rose = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!rose && out_valid) begin
        rose = 1'b1;
        chk("release_at_time", clock_count, 5);
      end
      cycle();
    end
    chk("release_seen", rose, 1);
    chk("release_back_idle", state, IDLE);

    // Fill to full with out_ready low, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_push(1'b1, 0);
      cycle();
    end
    in_valid = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, DEPTH);
    out_ready = 1'b1;
    repeat (DEPTH) cycle();
    chk("drain_empty", empty, 1);

    // Clock skipping over an idle gap
    do_reset();
    repeat (10) cycle();
    skip_en   = 1'b1;
    out_ready = 1'b1;
    set_push(1'b1, 1000);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("skip_clock_count", clock_count, 1000);
    chk("skip_out_valid", out_valid, 1);
    cycle();
    chk("skip_issued", empty, 1);
    skip_en = 1'b0;

    // Out-of-order time is clamped to the last pushed time
    do_reset();
    set_push(1'b1, 50);
    cycle();
    set_push(1'b1, 30);
    cycle();
    in_valid = 1'b0;
    chk("order_err_set", order_err, 1);
    skip_en   = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("clamped_count", count, 1);
    chk("clamped_valid", out_valid, 1);
    chk("clamped_time", out_time, 50);
    repeat (5) cycle();
    chk("order_err_sticky", order_err, 1);

    // Reset while issuing with entries queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_push(1'b1, 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    do_reset();
    cycle();
    chk("post_reset_out_valid", out_valid, 0);

    // Random traffic against the reference queue
    do_reset();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0 && m_last > 5)
        set_push($urandom_range(0, 1) == 1, m_last - 5);
      else
        set_push($urandom_range(0, 1) == 1, m_cc + $urandom_range(0, 30));
      out_ready = ($urandom_range(0, 3) != 0);
      skip_en   = ($urandom_range(0, 7) == 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    skip_en   = 1'b1;
    repeat (60) cycle();
    chk("random_drained", empty, 1);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
